// File: rtl/eth_port_arbiter_pkg.sv
// Shared types and defaults for the Ethernet port arbiter.
package eth_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN,
        GAP
    } arbStateType;

    localparam int ARB_IFG_CYCLES      = 4;
    localparam int MAX_ETH_FRAME_BYTES = 1522;
    localparam int BYTE_CNT_W          = 11;

endpackage

// File: rtl/eth_port_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester strictly after last_grant_i,
// wrapping around, with last_grant_i itself considered last.
module rr_picker #(
    parameter int NUM_PORTS = 2
) (
    input  logic [NUM_PORTS-1:0]         req_i,
    input  logic [$clog2(NUM_PORTS)-1:0] last_grant_i,
    output logic                         valid_o,
    output logic [$clog2(NUM_PORTS)-1:0] winner_o
);

    localparam int PORT_W = $clog2(NUM_PORTS);

    int idx;

    always_comb begin
        valid_o  = 1'b0;
        winner_o = '0;
        idx      = 0;
        for (int off = 1; off <= NUM_PORTS; off++) begin
            idx = (int'(last_grant_i) + off) % NUM_PORTS;
            if (!valid_o && req_i[PORT_W'(idx)]) begin
                valid_o  = 1'b1;
                winner_o = PORT_W'(idx);
            end
        end
    end

endmodule

// File: rtl/eth_port_arbiter.sv
// Frame-level round-robin arbiter feeding one parser from several byte-stream ports,
// with oversize policing, an enforced inter-frame gap and per-port frame counters.
//
// state  | meaning
// IDLE   | no grant; pick next requester round-robin
// STREAM | forward granted port's bytes, one cycle latency
// DRAIN  | oversize frame: accept and discard until last
// GAP    | inter-frame idle, all ports held off
module eth_port_arbiter
    import eth_port_arbiter_pkg::*;
#(
    parameter int NUM_PORTS       = 2,
    parameter int IFG_CYCLES      = ARB_IFG_CYCLES,
    parameter int MAX_FRAME_BYTES = MAX_ETH_FRAME_BYTES,
    parameter int CNT_W           = 32
) (
    input  logic                              clkIn,
    input  logic                              rstIn,
    input  logic [NUM_PORTS-1:0][7:0]         portDataIn,
    input  logic [NUM_PORTS-1:0]              portValidIn,
    input  logic [NUM_PORTS-1:0]              portLastIn,
    input  logic [NUM_PORTS-1:0]              portErrIn,
    output logic [NUM_PORTS-1:0]              portReadyOut,
    output logic [7:0]                        dataOut,
    output logic                              dataValidOut,
    output logic                              dataErrOut,
    output logic [$clog2(NUM_PORTS)-1:0]      activePortOut,
    output logic                              oversizeDropOut,
    output logic [NUM_PORTS-1:0][CNT_W-1:0]   frameCntOut
);

    localparam int PORT_W = $clog2(NUM_PORTS);
    localparam int GAP_W  = $clog2(IFG_CYCLES + 1);
    localparam logic [BYTE_CNT_W-1:0] MAX_CNT  = BYTE_CNT_W'(MAX_FRAME_BYTES);
    localparam logic [GAP_W-1:0]      GAP_LOAD = GAP_W'(IFG_CYCLES - 1);

    arbStateType                     state_q, state_d;
    logic [PORT_W-1:0]               grant_q, grant_d;
    logic [PORT_W-1:0]               last_grant_q, last_grant_d;
    logic [BYTE_CNT_W-1:0]           byte_cnt_q, byte_cnt_d;
    logic [GAP_W-1:0]                gap_cnt_q, gap_cnt_d;
    logic [7:0]                      data_q, data_d;
    logic                            valid_q, valid_d;
    logic                            err_q, err_d;
    logic                            drop_q, drop_d;
    logic [NUM_PORTS-1:0][CNT_W-1:0] frame_cnt_q, frame_cnt_d;

    logic              pick_valid;
    logic [PORT_W-1:0] pick_winner;
    logic              xfer;

    rr_picker #(
        .NUM_PORTS (NUM_PORTS)
    ) u_rr_picker (
        .req_i        (portValidIn),
        .last_grant_i (last_grant_q),
        .valid_o      (pick_valid),
        .winner_o     (pick_winner)
    );

    // Ready depends only on registered state so upstream never sees a loop through us.
    always_comb begin
        portReadyOut = '0;
        if (state_q == STREAM || state_q == DRAIN) begin
            portReadyOut[grant_q] = 1'b1;
        end
    end

    assign xfer = portValidIn[grant_q] & portReadyOut[grant_q];

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        byte_cnt_d   = byte_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        data_d       = data_q;
        valid_d      = 1'b0;
        err_d        = 1'b0;
        drop_d       = 1'b0;
        frame_cnt_d  = frame_cnt_q;

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_d      = pick_winner;
                    last_grant_d = pick_winner;
                    byte_cnt_d   = '0;
                    state_d      = STREAM;
                end
            end
            STREAM: begin
                if (xfer) begin
                    data_d     = portDataIn[grant_q];
                    valid_d    = 1'b1;
                    err_d      = portErrIn[grant_q];
                    byte_cnt_d = byte_cnt_q + BYTE_CNT_W'(1);
                    if (portLastIn[grant_q]) begin
                        frame_cnt_d[grant_q] = frame_cnt_q[grant_q] + CNT_W'(1);
                        byte_cnt_d           = '0;
                        gap_cnt_d            = GAP_LOAD;
                        state_d              = GAP;
                    end else if (byte_cnt_q == MAX_CNT) begin
                        // Mark the truncation point in-band so the parser rejects the frame.
                        err_d      = 1'b1;
                        drop_d     = 1'b1;
                        byte_cnt_d = '0;
                        state_d    = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (xfer && portLastIn[grant_q]) begin
                    gap_cnt_d = GAP_LOAD;
                    state_d   = GAP;
                end
            end
            GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clkIn) begin
        if (rstIn) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= PORT_W'(NUM_PORTS - 1);
            byte_cnt_q   <= '0;
            gap_cnt_q    <= '0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            err_q        <= 1'b0;
            drop_q       <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            byte_cnt_q   <= byte_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            err_q        <= err_d;
            drop_q       <= drop_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    assign dataOut         = data_q;
    assign dataValidOut    = valid_q;
    assign dataErrOut      = err_q;
    assign oversizeDropOut = drop_q;
    assign activePortOut   = grant_q;
    assign frameCntOut     = frame_cnt_q;

endmodule
